// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared defaults and state encoding for the UART burst scheduler
package uart_pkg;

  localparam int UART_DEPTH     = 8;
  localparam int UART_W         = 8;
  localparam int UART_TO_CYCLES = 1000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

endpackage

// File: rtl/burst_store.sv
// rtl/burst_store.sv - DEPTH x W register file, one sync write port, one comb read port
module burst_store
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_DEPTH,
  parameter int W     = UART_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
  input  logic [W-1:0]             i_wr_data,
  input  logic [$clog2(DEPTH)-1:0] i_rd_addr,
  output logic [W-1:0]             o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  // Storage is deliberately left unreset; a reset discards the burst via the pointers.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_burst_sched.sv
// rtl/uart_burst_sched.sv - collects RX bytes into bursts and drains them to the TX side
module uart_burst_sched
  import uart_pkg::*;
#(
  parameter int DEPTH     = UART_DEPTH,
  parameter int W         = UART_W,
  parameter int TO_CYCLES = UART_TO_CYCLES
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   rx_valid,
  input  logic [W-1:0]           rx_data,
  output logic                   rx_rdy,
  input  logic                   tx_rdy,
  output logic                   tx_valid,
  output logic [W-1:0]           tx_data,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic [CW-1:0] r_idle_cnt;
  logic          r_tx_valid;
  logic [W-1:0]  r_tx_data;

  logic          w_accept;
  logic          w_full;
  logic          w_timeout;
  logic [AW-1:0] w_rd_addr;
  logic [W-1:0]  w_rd_data;

  // Input side is open outside DRAIN as long as the buffer has room.
  always_comb begin
    rx_rdy = 1'b0;
    if (r_state == ST_IDLE) begin
      rx_rdy = 1'b1;
    end else if (r_state == ST_FILL) begin
      rx_rdy = (r_level < LW'(DEPTH));
    end
  end

  assign w_accept  = rx_valid && rx_rdy;
  assign w_full    = w_accept && (r_level == LW'(DEPTH - 1));
  assign w_timeout = (r_state == ST_FILL) && !w_accept && (r_idle_cnt == CW'(TO_CYCLES - 1));

  // While a byte is on offer the store already looks one entry ahead for back-to-back loads.
  assign w_rd_addr = r_tx_valid ? (r_rd_ptr + AW'(1)) : r_rd_ptr;

  burst_store #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_store (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (rx_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // Burst FSM: fill until full or idle timeout, then drain in arrival order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_idle_cnt <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_level    <= r_level + LW'(1);
            r_idle_cnt <= '0;
            r_state    <= w_full ? ST_DRAIN : ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_accept) begin
            r_wr_ptr   <= r_wr_ptr + AW'(1);
            r_level    <= r_level + LW'(1);
            r_idle_cnt <= '0;
            if (w_full) begin
              r_state <= ST_DRAIN;
            end
          end else if (w_timeout) begin
            r_idle_cnt <= '0;
            r_state    <= ST_DRAIN;
          end else begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
          end
        end
        ST_DRAIN: begin
          if (!r_tx_valid) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_rd_data;
          end else if (tx_rdy) begin
            if (r_level == LW'(1)) begin
              r_tx_valid <= 1'b0;
              r_wr_ptr   <= '0;
              r_rd_ptr   <= '0;
              r_level    <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_rd_ptr  <= r_rd_ptr + AW'(1);
              r_level   <= r_level - LW'(1);
              r_tx_data <= w_rd_data;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != ST_IDLE);
  assign level    = r_level;

endmodule
